// File: rtl/blowfish128_dec_core_if.sv
// blowfish128_dec_core_if: F-function request/response handshake.
// master drives X/ffunc_enable, slave returns Y/ffunc_ready.
interface blowfish128_dec_core_if #(
  parameter int HALF_W = 64
);
  logic [HALF_W-1:0] X;
  logic              ffunc_enable;
  logic [HALF_W-1:0] Y;
  logic              ffunc_ready;

  modport master (
    output X,
    output ffunc_enable,
    input  Y,
    input  ffunc_ready
  );

  modport slave (
    input  X,
    input  ffunc_enable,
    output Y,
    output ffunc_ready
  );
endinterface

// File: rtl/blowfish128_dec_core.sv
// blowfish128_dec_core: 128-bit Feistel decryption engine, external F.
// Macro BLOWFISH128_DEC_STATUS_EN adds busy/round_idx status outputs.
module blowfish128_dec_core #(
  parameter int NROUNDS = 8,
  parameter int HALF_W  = 64
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Enable,
  input  logic [2*HALF_W-1:0] cipherText,
  input  logic                skey_ready,
  input  logic [31:0]         P1,
  input  logic [31:0]         P2,
  input  logic [31:0]         P3,
  input  logic [31:0]         P4,
  input  logic [31:0]         P5,
  input  logic [31:0]         P6,
  input  logic [31:0]         P7,
  input  logic [31:0]         P8,
  input  logic [31:0]         P9,
  input  logic [31:0]         P10,
  input  logic [31:0]         P11,
  input  logic [31:0]         P12,
  input  logic [31:0]         P13,
  input  logic [31:0]         P14,
  input  logic [31:0]         P15,
  input  logic [31:0]         P16,
  input  logic [31:0]         P17,
  input  logic [31:0]         P18,
  input  logic [31:0]         P19,
  input  logic [31:0]         P20,
  output logic [2*HALF_W-1:0] plainText,
  output logic                plainReady,
  blowfish128_dec_core_if.master ffunc
`ifdef BLOWFISH128_DEC_STATUS_EN
  ,
  output logic                busy,
  output logic [3:0]          round_idx
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_XOR,
    S_WAIT,
    S_SWAP,
    S_FINAL,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [HALF_W-1:0]   lh_q, lh_d;
  logic [HALF_W-1:0]   rh_q, rh_d;
  logic [HALF_W-1:0]   x_q, x_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [2*HALF_W-1:0] pt_q, pt_d;
  logic                rdy_q, rdy_d;
  logic                fen_q, fen_d;

  logic [HALF_W-1:0] key [10];
  logic [HALF_W-1:0] krnd;
  logic              last_rnd;
  logic              start;

  assign key[0] = {P1, P2};
  assign key[1] = {P3, P4};
  assign key[2] = {P5, P6};
  assign key[3] = {P7, P8};
  assign key[4] = {P9, P10};
  assign key[5] = {P11, P12};
  assign key[6] = {P13, P14};
  assign key[7] = {P15, P16};
  assign key[8] = {P17, P18};
  assign key[9] = {P19, P20};

  // Rounds walk the schedule backwards: K10 first, K3 last.
  assign krnd     = key[4'd9 - cnt_q];
  assign last_rnd = (cnt_q == 4'(NROUNDS - 1));
  assign start    = Enable && skey_ready;

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_XOR;
      S_XOR:   state_d = S_WAIT;
      S_WAIT:  if (ffunc.ffunc_ready) state_d = S_SWAP;
      S_SWAP:  state_d = last_rnd ? S_FINAL : S_XOR;
      S_FINAL: state_d = S_DONE;
      S_DONE:  if (!Enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-state values.
  always_comb begin
    lh_d  = lh_q;
    rh_d  = rh_q;
    x_d   = x_q;
    cnt_d = cnt_q;
    pt_d  = pt_q;
    rdy_d = rdy_q;
    fen_d = fen_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lh_d  = cipherText[2*HALF_W-1:HALF_W];
          rh_d  = cipherText[HALF_W-1:0];
          cnt_d = 4'd0;
        end
      end
      S_XOR: begin
        lh_d  = lh_q ^ krnd;
        x_d   = lh_q ^ krnd;
        fen_d = 1'b1;
      end
      S_WAIT: begin
        if (ffunc.ffunc_ready) begin
          fen_d = 1'b0;
          rh_d  = rh_q ^ ffunc.Y;
        end
      end
      S_SWAP: begin
        if (!last_rnd) begin
          lh_d  = rh_q;
          rh_d  = lh_q;
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_FINAL: begin
        pt_d  = {lh_q ^ key[0], rh_q ^ key[1]};
        rdy_d = 1'b1;
      end
      S_DONE: begin
        if (!Enable) rdy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      lh_q  <= '0;
      rh_q  <= '0;
      x_q   <= '0;
      cnt_q <= '0;
      pt_q  <= '0;
      rdy_q <= 1'b0;
      fen_q <= 1'b0;
    end else begin
      lh_q  <= lh_d;
      rh_q  <= rh_d;
      x_q   <= x_d;
      cnt_q <= cnt_d;
      pt_q  <= pt_d;
      rdy_q <= rdy_d;
      fen_q <= fen_d;
    end
  end

  assign plainText          = pt_q;
  assign plainReady         = rdy_q;
  assign ffunc.X            = x_q;
  assign ffunc.ffunc_enable = fen_q;

`ifdef BLOWFISH128_DEC_STATUS_EN
  assign busy      = (state_q == S_XOR) || (state_q == S_WAIT) ||
                     (state_q == S_SWAP) || (state_q == S_FINAL);
  assign round_idx = cnt_q;
`endif

endmodule

// File: tb/tb_blowfish128_dec_core.sv
// tb_blowfish128_dec_core: directed checks of the decryption core
// against a bench-side Feistel model with a stub F-function.
module tb_blowfish128_dec_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         enable;
  logic         skey_ready;
  logic [127:0] cipher;
  logic [31:0]  P [1:20];
  logic [127:0] plain;
  logic         plain_rdy;
`ifdef BLOWFISH128_DEC_STATUS_EN
  logic         busy;
  logic [3:0]   ridx;
`endif

  blowfish128_dec_core_if fif ();

  blowfish128_dec_core dut (
    .Clk(clk), .Rst(rst), .Enable(enable),
    .cipherText(cipher), .skey_ready(skey_ready),
    .P1(P[1]), .P2(P[2]), .P3(P[3]), .P4(P[4]),
    .P5(P[5]), .P6(P[6]), .P7(P[7]), .P8(P[8]),
    .P9(P[9]), .P10(P[10]), .P11(P[11]), .P12(P[12]),
    .P13(P[13]), .P14(P[14]), .P15(P[15]), .P16(P[16]),
    .P17(P[17]), .P18(P[18]), .P19(P[19]), .P20(P[20]),
    .plainText(plain), .plainReady(plain_rdy),
    .ffunc(fif)
`ifdef BLOWFISH128_DEC_STATUS_EN
    , .busy(busy), .round_idx(ridx)
`endif
  );

  localparam logic [127:0] PT = 128'h123456ab_cd132536_123456ab_cd132536;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input bit ok, input string nm,
                     input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  bit zero_f = 1'b0;

  function automatic logic [63:0] kf(input int i);
    return {P[2*i-1], P[2*i]};
  endfunction

  function automatic logic [63:0] fm(input logic [63:0] x, input bit zf);
    if (zf) return 64'd0;
    return {x[31:0], x[63:32]} ^ (x * 64'h9E3779B97F4A7C15)
           ^ 64'h0123456789ABCDEF;
  endfunction

  function automatic logic [127:0] enc_model(input logic [127:0] p,
                                             input bit zf);
    logic [63:0] l, r, t;
    l = p[127:64];
    r = p[63:0];
    for (int i = 1; i <= 8; i++) begin
      l = l ^ kf(i);
      r = r ^ fm(l, zf);
      if (i < 8) begin t = l; l = r; r = t; end
    end
    return {l ^ kf(10), r ^ kf(9)};
  endfunction

  logic [63:0]  exp_x [8];
  logic [127:0] exp_plain;

  task automatic set_expect(input logic [127:0] c, input bit zf);
    logic [63:0] l, r, t;
    l = c[127:64];
    r = c[63:0];
    for (int i = 0; i < 8; i++) begin
      l = l ^ kf(10 - i);
      exp_x[i] = l;
      r = r ^ fm(l, zf);
      if (i < 7) begin t = l; l = r; r = t; end
    end
    exp_plain = {l ^ kf(1), r ^ kf(2)};
  endtask

  // ---------------- F stub ----------------
  logic        rst_at_edge = 1'b0;
  int          req_n       = 0;
  int          req_base    = 0;
  int          stall_round = -1;
  int          stall_extra = 0;
  int          fcnt        = 0;
  bit          pend        = 1'b0;
  logic [63:0] held_x;

  always @(posedge clk) rst_at_edge <= rst;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      fif.ffunc_ready = 1'b0;
      fif.Y = 64'd0;
      pend = 1'b0;
      fcnt = 0;
    end else if (fif.ffunc_ready) begin
      fif.ffunc_ready = 1'b0;
      pend = 1'b0;
      fcnt = 0;
    end else if (pend || fif.ffunc_enable) begin
      if (!pend) begin
        pend = 1'b1;
        held_x = fif.X;
        req_n++;
      end else begin
        chk(fif.ffunc_enable === 1'b1 && fif.X === held_x, "stall_hold",
            {63'd0, fif.ffunc_enable, fif.X}, {64'd1, held_x});
      end
      fcnt++;
      if (fif.ffunc_enable &&
          fcnt >= ((req_n - req_base - 1 == stall_round) ?
                   1 + stall_extra : 1)) begin
        fif.Y = fm(fif.X, zero_f);
        fif.ffunc_ready = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  int   gen = 0;
  int   seen_gen = 0;
  int   xi = 0;
  int   rises = 0;
  logic fen_prev = 1'b0;
  logic rdy_prev = 1'b0;

  always @(negedge clk) begin
    if (seen_gen != gen) begin
      seen_gen = gen;
      xi = 0;
    end
    if (rst_at_edge) begin
      chk(plain === 128'd0 && plain_rdy === 1'b0 && fif.X === 64'd0 &&
          fif.ffunc_enable === 1'b0, "reset_outs",
          {plain[127:2], plain_rdy, fif.ffunc_enable}, 128'd0);
`ifdef BLOWFISH128_DEC_STATUS_EN
      chk(busy === 1'b0 && ridx === 4'd0, "reset_status",
          {123'd0, busy, ridx}, 128'd0);
`endif
    end else begin
      if (fif.ffunc_enable && !fen_prev) begin
        if (xi < 8) begin
          chk(fif.X === exp_x[xi], "round_x", fif.X, exp_x[xi]);
          xi++;
        end else begin
          chk(1'b0, "extra_round", 128'(xi), 128'd7);
        end
      end
      if (plain_rdy) begin
        chk(plain === exp_plain, "plain", plain, exp_plain);
        if (!rdy_prev) rises++;
      end
    end
    fen_prev = fif.ffunc_enable;
    rdy_prev = plain_rdy;
  end

  // ---------------- directed runs ----------------
  task automatic run(input logic [127:0] c, input bit zf,
                     input int srnd, input int sext,
                     input int exp_lat, input string nm);
    int cyc;
    int r0;
    zero_f = zf;
    stall_round = srnd;
    stall_extra = sext;
    req_base = req_n;
    set_expect(c, zf);
    gen++;
    r0 = rises;
    cipher = c;
    skey_ready = 1'b1;
    enable = 1'b1;
    cyc = 0;
    while (cyc < 2000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (plain_rdy) break;
    end
    chk(plain_rdy === 1'b1, {nm, "_done"}, 128'(plain_rdy), 128'd1);
    chk(cyc == exp_lat, {nm, "_lat"}, 128'(cyc), 128'(exp_lat));
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk(plain_rdy === 1'b0, {nm, "_drop"}, 128'(plain_rdy), 128'd0);
    chk(plain === exp_plain, {nm, "_retain"}, plain, exp_plain);
    repeat (2) @(negedge clk);
    chk(rises - r0 == 1, {nm, "_once"}, 128'(rises - r0), 128'd1);
  endtask

  logic [127:0] ct;
  logic [127:0] zlit;
  int           wcnt;

  initial begin
    P[1]  = 32'h8e846390; P[2]  = 32'ha295c40e;
    P[3]  = 32'hb9a28336; P[4]  = 32'h2446bf99;
    P[5]  = 32'h0eb2313a; P[6]  = 32'h0ea9fd0d;
    P[7]  = 32'ha295f380; P[8]  = 32'hcb78a054;
    P[9]  = 32'hef9328fe; P[10] = 32'h1fe6dfaa;
    P[11] = 32'h14ef6fd7; P[12] = 32'h13dfc0b1;
    P[13] = 32'h6a1720af; P[14] = 32'hee4a9c00;
    P[15] = 32'h953fdcad; P[16] = 32'h9271c5ca;
    P[17] = 32'h38addcc1; P[18] = 32'hae4f37c6;
    P[19] = 32'hfd34d6fb; P[20] = 32'h1df5be3b;
    fif.Y = 64'd0;
    fif.ffunc_ready = 1'b0;
    rst = 1'b1;
    enable = 1'b1;
    skey_ready = 1'b1;
    cipher = 128'hdeadbeef;

    // reset held with Enable high
    repeat (5) @(negedge clk);
    rst = 1'b0;
    enable = 1'b0;
    @(negedge clk);

    // zero-F stub: result is a pure XOR fold of the schedule
    zlit = {P[1] ^ P[5] ^ P[9]  ^ P[13] ^ P[17],
            P[2] ^ P[6] ^ P[10] ^ P[14] ^ P[18],
            P[3] ^ P[7] ^ P[11] ^ P[15] ^ P[19],
            P[4] ^ P[8] ^ P[12] ^ P[16] ^ P[20]};
    set_expect(128'd0, 1'b1);
    chk(exp_plain === zlit, "model_zero_pin", exp_plain, zlit);
    run(128'd0, 1'b1, -1, 0, 26, "zero_f");
    chk(plain === zlit, "zero_f_lit", plain, zlit);

    // round trip through the encryption schedule
    ct = enc_model(PT, 1'b0);
    set_expect(ct, 1'b0);
    chk(exp_plain === PT, "model_rt_pin", exp_plain, PT);
    run(ct, 1'b0, -1, 0, 26, "rt");
    chk(plain === PT, "rt_lit", plain, PT);

    // 7-cycle stall in round 3
    run(ct, 1'b0, 2, 7, 33, "stall");
    chk(plain === PT, "stall_lit", plain, PT);

    // Enable without subkeys: no capture
    cipher = ct;
    skey_ready = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk(fif.ffunc_enable === 1'b0 && plain_rdy === 1'b0, "gate_idle",
          {126'd0, fif.ffunc_enable, plain_rdy}, 128'd0);
    end
    run(ct, 1'b0, -1, 0, 26, "gate");
    chk(plain === PT, "gate_lit", plain, PT);

    // reset during round 4 WAIT
    zero_f = 1'b0;
    stall_round = 3;
    stall_extra = 20;
    req_base = req_n;
    set_expect(ct, 1'b0);
    gen++;
    cipher = ct;
    skey_ready = 1'b1;
    enable = 1'b1;
    wcnt = 0;
    while (req_n - req_base < 4 && wcnt < 500) begin
      @(negedge clk);
      wcnt++;
    end
    chk(req_n - req_base == 4, "abort_reach", 128'(req_n - req_base), 128'd4);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk(plain === 128'd0 && plain_rdy === 1'b0 && fif.X === 64'd0 &&
        fif.ffunc_enable === 1'b0, "abort_zero",
        {plain[127:2], plain_rdy, fif.ffunc_enable}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    run(ct, 1'b0, -1, 0, 26, "fresh");
    chk(plain === PT, "fresh_lit", plain, PT);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/blowfish128_dec_core.md
Name: blowfish128_dec_core

Overview:
- Decryption counterpart of the blowfish128 encryption core: a 128-bit Feistel engine that recovers the plaintext from a 128-bit ciphertext.
- Uses the same 20×32-bit subkey set P1..P20.
- Shares the external blowfish128_ffunc block over the same X/Y/ffunc_enable/ffunc_ready handshake.
- Sits beside the encryption core; the subkey generator feeds both.

Parameters:
- NROUNDS, 8: Feistel rounds; must be 8 for the 20-subkey schedule.
- HALF_W, 64: width of each Feistel half.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous, active-high reset.
- Enable  input  1  level request to decrypt cipherText.
- cipherText  input  128  ciphertext block; [127:64] is lH, [63:0] is rH.
- skey_ready  input  1  P1..P20 are valid.
- P1..P20  input  32 each  subkeys; 64-bit round key K_i = {P(2i-1), P(2i)}, i=1..10.
- plainText  output  128  recovered plaintext.
- plainReady  output  1  plainText valid.
- X  output  64  F-function operand to ffunc.
- ffunc_enable  output  1  F-function request.
- Y  input  64  F-function result.
- ffunc_ready  input  1  Y valid.

Behaviour:
- Reset (Rst=1 at a Clk edge; also forces any mid-operation reset): state=IDLE, lH=rH=0, rCounter=0, plainText=0, plainReady=0, X=0, ffunc_enable=0.
- IDLE:
  - If Enable && skey_ready: lH<=cipherText[127:64], rH<=cipherText[63:0], rCounter<=0, go to XOR.
  - Enable without skey_ready: stay in IDLE, nothing captured.
- XOR (1 cycle): lH<=lH^K(10-rCounter); X<=lH^K(10-rCounter); ffunc_enable<=1; go to WAIT.
- WAIT:
  - X and ffunc_enable held stable until ffunc_ready=1 is sampled.
  - On that cycle: ffunc_enable<=0; rH<=rH^Y; go to SWAP.
  - No timeout; ffunc latency is unbounded.
- SWAP (1 cycle):
  - If rCounter<NROUNDS-1: {lH,rH}<={rH,lH}, rCounter++, go to XOR.
  - Else: no swap, go to FINAL.
- FINAL (1 cycle): plainText<={lH^K1, rH^K2}; plainReady<=1; go to DONE.
- DONE:
  - plainReady=1 and plainText held while Enable=1.
  - Enable=0: plainReady<=0, go to IDLE. plainText retains its last value.
  - A new block therefore needs Enable to drop for at least one cycle.
- Latency: Enable sample to plainReady = 1 (capture) + 8×(1 XOR + Lf + 1 SWAP) + 1 FINAL cycles, where Lf is the ffunc cycles from enable to ready.
- Enable deasserted mid-operation: ignored. The block runs to completion and drops to IDLE from DONE on the next cycle.
- skey_ready and P1..P20 must stay stable from capture to FINAL; the block does not latch subkeys.
- cipherText is sampled only at capture.
- rCounter is 4 bits and never exceeds NROUNDS-1.
- Inverse property: decrypt(encrypt(p,P),P)=p for the encryption core's schedule (rounds K1..K8, whitening rH^K9, lH^K10).

Optional Feature:
- Macro BLOWFISH128_DEC_STATUS_EN.
- Defined: adds output busy (1 bit; high in XOR/WAIT/SWAP/FINAL, 0 on reset) and output round_idx (4 bits; mirrors rCounter, 0 on reset).
- Undefined: these ports do not exist; core behaviour is identical.

Test Plan:
- Reset: hold Rst=1 for 5 cycles with Enable=1 → plainReady=0, ffunc_enable=0, plainText=0, X=0 throughout.
- Round trip:
  - Subkeys P1..P20 = 8e846390, a295c40e, b9a28336, 2446bf99, 0eb2313a, 0ea9fd0d, a295f380, cb78a054, ef9328fe, 1fe6dfaa, 14ef6fd7, 13dfc0b1, 6a1720af, ee4a9c00, 953fdcad, 9271c5ca, 38addcc1, ae4f37c6, fd34d6fb, 1df5be3b.
  - Feed the encryption core's cipherText for plaintext 1234_56ab_cd13_2536_1234_56ab_cd13_2536 → plainText equals that plaintext, and plainReady rises exactly once.
- Zero-F stub: ffunc returns Y=0 with ready after 1 cycle, cipherText=0 → plainText equals the bench XOR model of K1..K10. Total latency = 1+8×3+1 = 26 cycles.
- Stall: ffunc_ready delayed 7 cycles in round 3 → X and ffunc_enable are stable across all stalled cycles; result equals the unstalled run.
- skey_ready gating: Enable=1, skey_ready=0 for 10 cycles → no capture. Raise skey_ready → capture on the next edge.
- Mid-operation reset: assert Rst during round 4 WAIT → next cycle all outputs are 0, state is IDLE. A fresh run then returns the correct plaintext.
